// File: rtl/digit_serial_addsub_pkg.sv
// ============================================================================
// Module : addsub_pkg
// Brief  : Shared FSM state and mode encodings for digit_serial_addsub.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/digit_serial_addsub_digit_adder.sv
// ============================================================================
// Module : digit_adder
// Brief  : Combinational DIGIT-bit ripple-carry slice of full-adder cells.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_adder #(
   parameter int DIGIT = 8
) (
   input  logic             cin,
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_fa
         assign sum[i]       = a[i] ^ b[i] ^ carry[i];
         assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout     = carry[DIGIT];
   // The carry entering the top bit, paired with cout, yields signed overflow.
   assign c_msb_in = carry[DIGIT - 1];

endmodule

`default_nettype wire

// File: rtl/digit_serial_addsub.sv
// ============================================================================
// Module : digit_serial_addsub
// Brief  : WIDTH-bit add/subtract reusing one DIGIT-bit slice over NDIG cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [DIGIT-1:0] slice_a;
   logic [DIGIT-1:0] slice_b;
   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_c_msb;
   int               lsb;

   // B is inverted in subtract mode; the initial carry (cin ^ sub) supplies the +1.
   always_comb begin
      lsb     = int'(idx_q) * DIGIT;
      slice_a = a_q[lsb +: DIGIT];
      slice_b = b_q[lsb +: DIGIT] ^ {DIGIT{sub_q == SUB}};
   end

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_slice (
      .cin      (carry_q),
      .a        (slice_a),
      .b        (slice_b),
      .sum      (slice_sum),
      .cout     (slice_cout),
      .c_msb_in (slice_c_msb)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               carry_d = cin ^ sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[lsb +: DIGIT] = slice_sum;
            carry_d             = slice_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
               ovf_d   = slice_c_msb ^ slice_cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= ADD;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
// ============================================================================
// Module : tb_digit_serial_addsub
// Brief  : Self-checking bench for digit_serial_addsub (vectors + corner cases).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_addsub;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              sub;
   logic              cin;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              ovf;

   // Shared stimulus for the DIGIT sweep instances.
   logic              sw_in_valid;
   logic              sw_sub;
   logic              sw_cin;
   logic [WIDTH-1:0]  sw_a;
   logic [WIDTH-1:0]  sw_b;
   logic              sw_out_ready;
   logic [2:0]        sw_in_ready;
   logic [2:0]        sw_out_valid;
   logic [2:0]        sw_cout;
   logic [2:0]        sw_ovf;
   logic [WIDTH-1:0]  sw_sum [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   digit_serial_addsub #(
      .WIDTH (WIDTH),
      .DIGIT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sub       (sub),
      .cin       (cin),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   generate
      for (genvar g = 0; g < 3; g++) begin : g_sweep
         localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
         digit_serial_addsub #(
            .WIDTH (WIDTH),
            .DIGIT (DG)
         ) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[g]),
            .sub       (sw_sub),
            .cin       (sw_cin),
            .a         (sw_a),
            .b         (sw_b),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .sum       (sw_sum[g]),
            .cout      (sw_cout[g]),
            .ovf       (sw_ovf[g])
         );
      end
   endgenerate

   typedef struct {
      logic        s;
      logic        c;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] esum;
      logic        eco;
      logic        eov;
   } vec_t;

   vec_t vecs [9];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One operation on the main instance; lat = edges from accept to out_valid (0 = timeout).
   task automatic run_op(input logic s, input logic c, input logic [31:0] oa, input logic [31:0] ob,
                         output logic [31:0] rs, output logic rc, output logic ro, output int lat);
      in_valid = 1'b1;
      sub      = s;
      cin      = c;
      a        = oa;
      b        = ob;
      tick();
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      sub      = ~s;
      cin      = ~c;
      lat      = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      rs = sum;
      rc = cout;
      ro = ovf;
      if (out_ready) tick();
   endtask

   // Reference: effective B and carry-in, then a plain 33-bit add.
   function automatic logic [63:0] ref_pack(input logic s, input logic c,
                                            input logic [31:0] ra, input logic [31:0] rb,
                                            input int lat);
      logic [31:0] bb;
      logic        ci;
      logic [32:0] full;
      logic        ov;
      bb   = s ? ~rb : rb;
      ci   = c ^ s;
      full = {1'b0, ra} + {1'b0, bb} + {32'd0, ci};
      ov   = (ra[31] == bb[31]) && (full[31] != ra[31]);
      return {lat[7:0], 22'd0, full[32], ov, full[31:0]};
   endfunction

   initial begin
      logic [31:0] rs;
      logic        rc;
      logic        ro;
      int          lat;
      logic [31:0] held;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0006, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      sub          = 1'b0;
      cin          = 1'b0;
      a            = '0;
      b            = '0;
      out_ready    = 1'b1;
      sw_in_valid  = 1'b0;
      sw_sub       = 1'b0;
      sw_cin       = 1'b0;
      sw_a         = '0;
      sw_b         = '0;
      sw_out_ready = 1'b1;

      tick();
      tick();
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_sum", {32'd0, sum}, 64'd0);
      check("reset_cout_ovf", {62'd0, cout, ovf}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Directed vectors at DIGIT=8: latency must be exactly 4 edges.
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].s, vecs[i].c, vecs[i].va, vecs[i].vb, rs, rc, ro, lat);
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'd4);
         check($sformatf("vec%0d_sum", i), {32'd0, rs}, {32'd0, vecs[i].esum});
         check($sformatf("vec%0d_cout", i), {63'd0, rc}, {63'd0, vecs[i].eco});
         check($sformatf("vec%0d_ovf", i), {63'd0, ro}, {63'd0, vecs[i].eov});
      end

      // Backpressure: result held in DONE while inputs churn.
      out_ready = 1'b0;
      run_op(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0023, rs, rc, ro, lat);
      check("bp_lat", 64'(lat), 64'd4);
      held = rs;
      check("bp_sum", {32'd0, held}, 64'h123);
      for (int k = 0; k < 5; k++) begin
         a        = $urandom;
         b        = $urandom;
         in_valid = k[0];
         tick();
         check($sformatf("bp_hold%0d", k), {30'd0, out_valid, in_ready, sum}, {30'd0, 1'b1, 1'b0, 32'h0000_0123});
         check($sformatf("bp_flags%0d", k), {62'd0, cout, ovf}, 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release", {62'd0, out_valid, in_ready}, 64'd1);

      // Reset asserted at the second RUN edge aborts silently.
      in_valid = 1'b1;
      sub      = 1'b0;
      cin      = 1'b0;
      a        = 32'h1111_1111;
      b        = 32'h2222_2222;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("rst_run_state", {62'd0, in_ready, out_valid}, 64'd2);
      check("rst_run_sum", {32'd0, sum}, 64'd0);
      rst_n = 1'b1;
      held  = 32'd0;
      for (int k = 0; k < 6; k++) begin
         tick();
         held = held | {31'd0, out_valid};
      end
      check("rst_no_result", {32'd0, held}, 64'd0);
      run_op(1'b0, 1'b0, 32'd3, 32'd4, rs, rc, ro, lat);
      check("post_rst_lat", 64'(lat), 64'd4);
      check("post_rst_sum", {32'd0, rs}, 64'd7);

      // DIGIT sweep {1,4,32}: all three accept on the same edge.
      for (int op = 0; op < 1000; op++) begin
         logic [31:0] ra, rb;
         logic        rsb, rci;
         int          slat [3];
         logic [31:0] ssum [3];
         logic        sco  [3];
         logic        sov  [3];
         ra  = $urandom;
         rb  = $urandom;
         if ((op % 7) == 0) ra = 32'h8000_0000;
         if ((op % 11) == 0) rb = 32'hFFFF_FFFF;
         if ((op % 13) == 0) ra = 32'h7FFF_FFFF;
         rsb = 1'($urandom_range(0, 1));
         rci = 1'($urandom_range(0, 1));
         check($sformatf("sw%0d_idle", op), {61'd0, sw_in_ready}, 64'd7);
         sw_a        = ra;
         sw_b        = rb;
         sw_sub      = rsb;
         sw_cin      = rci;
         sw_in_valid = 1'b1;
         tick();
         sw_in_valid = 1'b0;
         sw_a        = ~ra;
         sw_b        = ~rb;
         for (int g = 0; g < 3; g++) begin
            slat[g] = 0;
            ssum[g] = '0;
            sco[g]  = 1'b0;
            sov[g]  = 1'b0;
         end
         for (int k = 1; k <= 40; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
               if (sw_out_valid[g] && slat[g] == 0) begin
                  slat[g] = k;
                  ssum[g] = sw_sum[g];
                  sco[g]  = sw_cout[g];
                  sov[g]  = sw_ovf[g];
               end
            end
         end
         check($sformatf("sw%0d_d1", op), {slat[0][7:0], 22'd0, sco[0], sov[0], ssum[0]}, ref_pack(rsb, rci, ra, rb, 32));
         check($sformatf("sw%0d_d4", op), {slat[1][7:0], 22'd0, sco[1], sov[1], ssum[1]}, ref_pack(rsb, rci, ra, rb, 8));
         check($sformatf("sw%0d_d32", op), {slat[2][7:0], 22'd0, sco[2], sov[2], ssum[2]}, ref_pack(rsb, rci, ra, rb, 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
